// File: rtl/tm1638_sang_don.sv
// TM1638 step display driver.
// Each rising edge of step_clk lights one more LED (0..8 lit, then wraps to
// none). Every change of the pattern is pushed to the TM1638 as a full frame:
// data-command, address + 16 data bytes, display-control.
//
// Handshake note: there is no valid/ready pair here. step_clk is a free-running
// asynchronous request. Any number of steps that land while a frame is on the
// wire collapse into a single pending flag, so the frame that follows always
// carries the newest pattern. busy is high for the whole frame.
`timescale 1ns/1ps
module tm1638_sang_don #(
    parameter int HALF_DIV = 25,
    parameter int STB_GAP  = 50
) (
    input  logic       clki,
    input  logic       rst,
    input  logic       step_clk,
    output logic       stb,
    output logic       sclk,
    output logic       dio,
    output logic       busy,
    output logic [7:0] led_state,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STB_LO  = 3'd1,
        BIT_LO  = 3'd2,
        BIT_HI  = 3'd3,
        GRP_END = 3'd4,
        GAP     = 3'd5
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(STB_GAP - 1);

    state_t      state;
    logic        sync0, sync1, sync1_d;
    logic [1:0]  fill;
    logic        step_pulse;
    logic [3:0]  lit_cnt;
    logic        pending;
    logic        boot;
    logic [7:0]  frame;
    logic [7:0]  div;
    logic [2:0]  bit_cnt;
    logic [4:0]  byte_cnt;
    logic [1:0]  grp;
    logic [4:0]  nxt_idx;
    logic [2:0]  nxt_bit;
    logic [7:0]  nxt_byte;
    logic        last_byte;

    assign dbg_state = state;

    // Byte on the wire for a given group / byte position within that group.
    // Group 1 carries the address byte followed by D0..D15, where only the odd
    // D bytes hold an LED bit (bit 0 of the byte).
    function automatic logic [7:0] byte_of(input logic [1:0] g,
                                           input logic [4:0] idx,
                                           input logic [7:0] pat);
        logic [3:0] d_idx;
        logic [7:0] b;
        d_idx = idx[3:0] - 4'd1;
        b     = 8'h8F;
        case (g)
            2'd0: b = 8'h40;
            2'd1: begin
                if (idx == 5'd0)
                    b = 8'hC0;
                else if (d_idx[0])
                    b = {7'b0, pat[d_idx[3:1]]};
                else
                    b = 8'h00;
            end
            default: b = 8'h8F;
        endcase
        return b;
    endfunction

    // 2-FF synchroniser plus registered rising-edge detect. fill keeps the
    // detector blind until both compared flops hold real samples, so a
    // step_clk that is already high at reset release is not taken as a step.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            sync0      <= 1'b0;
            sync1      <= 1'b0;
            sync1_d    <= 1'b0;
            fill       <= 2'd0;
            step_pulse <= 1'b0;
        end else begin
            sync0      <= step_clk;
            sync1      <= sync0;
            sync1_d    <= sync1;
            if (fill != 2'd3)
                fill <= fill + 2'd1;
            step_pulse <= (fill == 2'd3) && sync1 && !sync1_d;
        end
    end

    // Lit count and thermometer LED pattern; 8 lit wraps to none.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            lit_cnt   <= 4'd0;
            led_state <= 8'h00;
        end else if (step_pulse) begin
            if (lit_cnt == 4'd8) begin
                lit_cnt   <= 4'd0;
                led_state <= 8'h00;
            end else begin
                lit_cnt   <= lit_cnt + 4'd1;
                led_state <= {led_state[6:0], 1'b1};
            end
        end
    end

    // Which bit goes on dio at the next sclk fall: the first bit of the group
    // from STB_LO, otherwise the bit after the one currently in its high phase.
    always_comb begin
        nxt_idx = byte_cnt;
        nxt_bit = bit_cnt;
        if (state == BIT_HI) begin
            nxt_bit = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
                nxt_idx = byte_cnt + 5'd1;
        end
        nxt_byte  = byte_of(grp, nxt_idx, frame);
        last_byte = (grp == 2'd1) ? (byte_cnt == 5'd16) : 1'b1;
    end

    // Frame sequencer: pending/snapshot handling and the serial line timing.
    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= 8'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 5'd0;
            grp      <= 2'd0;
            frame    <= 8'h00;
            stb      <= 1'b1;
            sclk     <= 1'b1;
            dio      <= 1'b1;
            busy     <= 1'b0;
            pending  <= 1'b0;
            boot     <= 1'b1;
        end else begin
            boot <= 1'b0;
            // A step in the same cycle as the frame launch keeps pending set.
            if (state == IDLE && pending)
                pending <= step_pulse;
            else if (step_pulse || boot)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (pending) begin
                        frame    <= led_state;
                        busy     <= 1'b1;
                        stb      <= 1'b0;
                        div      <= 8'd0;
                        grp      <= 2'd0;
                        byte_cnt <= 5'd0;
                        bit_cnt  <= 3'd0;
                        state    <= STB_LO;
                    end
                end
                STB_LO: begin
                    if (div == HALF_LAST) begin
                        div   <= 8'd0;
                        sclk  <= 1'b0;
                        dio   <= nxt_byte[nxt_bit];
                        state <= BIT_LO;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                BIT_LO: begin
                    if (div == HALF_LAST) begin
                        div   <= 8'd0;
                        sclk  <= 1'b1;
                        state <= BIT_HI;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                BIT_HI: begin
                    if (div == HALF_LAST) begin
                        div <= 8'd0;
                        if (bit_cnt == 3'd7 && last_byte) begin
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 5'd0;
                            dio      <= 1'b1;
                            state    <= GRP_END;
                        end else begin
                            if (bit_cnt == 3'd7)
                                byte_cnt <= byte_cnt + 5'd1;
                            bit_cnt <= bit_cnt + 3'd1;
                            sclk    <= 1'b0;
                            dio     <= nxt_byte[nxt_bit];
                            state   <= BIT_LO;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                GRP_END: begin
                    if (div == HALF_LAST) begin
                        div   <= 8'd0;
                        stb   <= 1'b1;
                        state <= GAP;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                GAP: begin
                    if (div == GAP_LAST) begin
                        div <= 8'd0;
                        if (grp == 2'd2) begin
                            grp   <= 2'd0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            grp   <= grp + 2'd1;
                            stb   <= 1'b0;
                            state <= STB_LO;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_sang_don.sv
// Directed bench for tm1638_sang_don: a line monitor decodes the serial
// stream and checks line timing; the main sequence drives steps and resets.
`timescale 1ns/1ps
module tb_tm1638_sang_don;

    localparam int H     = 4;
    localparam int G     = 6;
    localparam int FRAME = 3 * (2 * H + G) + 152 * 2 * H;   // 1258

    // ---------------- clock / reset ----------------
    logic       clki = 1'b0;
    logic       rst;
    logic       step_clk;
    logic       stb, sclk, dio, busy;
    logic [7:0] led_state;
    logic [2:0] dbg_state;

    always #5 clki = ~clki;

    tm1638_sang_don #(.HALF_DIV(H), .STB_GAP(G)) dut (
        .clki      (clki),
        .rst       (rst),
        .step_clk  (step_clk),
        .stb       (stb),
        .sclk      (sclk),
        .dio       (dio),
        .busy      (busy),
        .led_state (led_state),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_bytes[$];
    int         grp_len[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    logic       p_stb, p_sclk, p_dio;
    int         stb_run, sclk_run, bitn, grp_bytes, frame_bits;
    logic       gap_busy;
    logic [7:0] shreg;

    always @(negedge clki) begin
        if (rst) begin
            rx_bytes.delete();
            grp_len.delete();
            p_stb = 1'b1; p_sclk = 1'b1; p_dio = 1'b1;
            stb_run = 0; sclk_run = 0; bitn = 0; grp_bytes = 0; frame_bits = 0;
            gap_busy = 1'b0; shreg = 8'h00;
        end else begin
            if (stb !== p_stb) begin
                if (stb === 1'b0) begin
                    if (gap_busy)
                        check("stb_gap", stb_run, G);
                    else
                        frame_bits = 0;
                    sclk_run = 1; bitn = 0; grp_bytes = 0;
                end else begin
                    check("sclk_tail", sclk_run, 2 * H);
                    grp_len.push_back(grp_bytes);
                    gap_busy = 1'b1;
                end
                stb_run = 1;
            end else begin
                if (stb === 1'b1 && gap_busy && busy === 1'b0) begin
                    check("stb_last_gap", stb_run, G);
                    gap_busy = 1'b0;
                end
                stb_run++;
                if (stb === 1'b0) begin
                    if (sclk !== p_sclk) begin
                        if (sclk === 1'b1) begin
                            check("sclk_lo", sclk_run, H);
                            check("dio_hold", {31'b0, dio}, {31'b0, p_dio});
                            shreg = {dio, shreg[7:1]};
                            bitn++;
                            frame_bits++;
                            if (bitn == 8) begin
                                rx_bytes.push_back(shreg);
                                grp_bytes++;
                                bitn = 0;
                            end
                        end else begin
                            check("sclk_hi", sclk_run, H);
                        end
                        sclk_run = 1;
                    end else begin
                        sclk_run++;
                    end
                end
            end
            if (stb === 1'b1)
                check("idle_lines", {30'b0, sclk, dio}, 32'd3);
            p_stb = stb; p_sclk = sclk; p_dio = dio;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_step();
        step_clk = 1'b1;
        repeat (6) @(negedge clki);
        step_clk = 1'b0;
        repeat (6) @(negedge clki);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag);
        int c;
        c = 0;
        while (busy !== lvl && c < budget) begin
            @(negedge clki);
            c++;
        end
        check(tag, {31'b0, busy}, {31'b0, lvl});
    endtask

    task automatic check_frame(input logic [7:0] pat, input string tag);
        logic [7:0] got;
        exp_q.delete();
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back({7'b0, pat[k]});
        end
        exp_q.push_back(8'h8F);
        check({tag, "_nbytes"}, rx_bytes.size(), 19);
        for (int i = 0; i < 19; i++) begin
            got = (rx_bytes.size() > 0) ? rx_bytes.pop_front() : 8'hEE;
            check($sformatf("%s_b%0d", tag, i), {24'b0, got}, {24'b0, exp_q[i]});
        end
        check({tag, "_ngrp"}, grp_len.size(), 3);
        if (grp_len.size() == 3) begin
            check({tag, "_g1len"}, grp_len[0], 1);
            check({tag, "_g2len"}, grp_len[1], 17);
            check({tag, "_g3len"}, grp_len[2], 1);
        end
        rx_bytes.delete();
        grp_len.delete();
    endtask

    // Release reset and follow the automatic power-up frame (pattern 0x00).
    task automatic release_and_frame(input string tag);
        int cnt;
        int len;
        rst = 1'b0;
        cnt = 0;
        while (busy !== 1'b1 && cnt < 10) begin
            @(negedge clki);
            cnt++;
        end
        check({tag, "_busy_rise"}, {31'b0, (busy === 1'b1 && cnt <= 2)}, 32'd1);
        len = 0;
        while (busy === 1'b1 && len < 3 * FRAME) begin
            @(negedge clki);
            len++;
        end
        check({tag, "_frame_len"}, len, FRAME);
        check_frame(8'h00, tag);
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] pat_tab [9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};

    initial begin
        int  c;
        logic saw;
        rst = 1'b1;
        step_clk = 1'b0;
        repeat (3) @(negedge clki);

        // reset state
        check("rst_stb",  {31'b0, stb},  32'd1);
        check("rst_sclk", {31'b0, sclk}, 32'd1);
        check("rst_dio",  {31'b0, dio},  32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_led",  {24'b0, led_state}, 32'h00);
        check("rst_state", {29'b0, dbg_state}, 32'd0);

        // power-up frame
        release_and_frame("pwrup");

        // nine steps, one frame each; the ninth wraps back to all-off
        for (int k = 0; k < 9; k++) begin
            do_step();
            check($sformatf("led_step%0d", k + 1), {24'b0, led_state}, {24'b0, pat_tab[k]});
            wait_busy(1'b1, 20, $sformatf("busy_hi_step%0d", k + 1));
            wait_busy(1'b0, FRAME + 20, $sformatf("busy_lo_step%0d", k + 1));
            check_frame(pat_tab[k], $sformatf("frm_step%0d", k + 1));
        end

        // two steps inside one frame coalesce into one follow-up frame
        do_step();
        check("led_coal_a", {24'b0, led_state}, 32'h01);
        wait_busy(1'b1, 20, "coal_busy_a");
        do_step();
        do_step();
        check("led_coal_c", {24'b0, led_state}, 32'h07);
        wait_busy(1'b0, FRAME + 20, "coal_lo_a");
        check_frame(8'h01, "frm_coal_a");
        wait_busy(1'b1, 10, "coal_busy_b");
        wait_busy(1'b0, FRAME + 20, "coal_lo_b");
        check_frame(8'h07, "frm_coal_b");
        saw = 1'b0;
        repeat (FRAME) begin
            @(negedge clki);
            if (busy === 1'b1) saw = 1'b1;
        end
        check("coal_no_third", {31'b0, saw}, 32'd0);
        check("coal_no_bytes", rx_bytes.size(), 0);

        // reset in the middle of a frame
        do_step();
        check("led_pre_abort", {24'b0, led_state}, 32'h0F);
        c = 0;
        while (frame_bits < 50 && c < FRAME) begin
            @(negedge clki);
            c++;
        end
        check("abort_reached_bit50", {31'b0, (frame_bits >= 50)}, 32'd1);
        check("abort_stb_before", {31'b0, stb}, 32'd0);
        @(posedge clki);
        #2 rst = 1'b1;
        #1;
        check("abort_stb",  {31'b0, stb},  32'd1);
        check("abort_sclk", {31'b0, sclk}, 32'd1);
        check("abort_dio",  {31'b0, dio},  32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_led",  {24'b0, led_state}, 32'h00);
        check("abort_state", {29'b0, dbg_state}, 32'd0);
        repeat (3) @(negedge clki);
        release_and_frame("postabort");

        // step_clk held high across reset release is not a step
        step_clk = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clki);
        release_and_frame("hiclk");
        check("hiclk_led", {24'b0, led_state}, 32'h00);
        saw = 1'b0;
        repeat (200) begin
            @(negedge clki);
            if (busy === 1'b1) saw = 1'b1;
        end
        check("hiclk_no_frame", {31'b0, saw}, 32'd0);
        step_clk = 1'b0;
        repeat (6) @(negedge clki);
        do_step();
        check("hiclk_led_live", {24'b0, led_state}, 32'h01);
        wait_busy(1'b1, 20, "hiclk_busy_hi");
        wait_busy(1'b0, FRAME + 20, "hiclk_busy_lo");
        check_frame(8'h01, "frm_hiclk");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // overall time bound
    initial begin
        #(2_000_000);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
